// File: rtl/bus_pkg.sv
// Shared definitions for the memory/peripheral bus arbiters: FSM encoding,
// master index constants, default bus widths and a counter-width helper.
package bus_pkg;

  // Arbiter FSM encoding: idle, slave request outstanding, master response.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } arb_state_e;

  // Master indices as seen by the two-way picker.
  localparam logic M_CORE   = 1'b0;
  localparam logic M_LOADER = 1'b1;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  // Width of a counter that must hold 0..limit; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = 1;
    while ((limit >> w) != 0) w++;
    return w;
  endfunction

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way request picker. With rr_en set, a contended pick goes
// to the master that did not win last time; otherwise master 0 always wins.
module arb_pick2
  import bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       rr_en,
  output logic       grant,
  output logic       valid
);

  // Select the winning index from the request vector.
  always_comb begin
    valid = |req;
    grant = M_CORE;
    if (req == 2'b11) begin
      grant = rr_en ? ~last_grant : M_CORE;
    end else if (req[1]) begin
      grant = M_LOADER;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-master, one-slave arbiter for the shared memory/peripheral port.
// Master 0 is the core, master 1 the loader/debug port. A transfer is
// captured in IDLE, presented to the slave in ISSUE until s_ack or timeout,
// and reported to the granted master for one cycle in RESP.
// Optional feature: define ARBITER_ROUND_ROBIN_EN for round-robin arbitration
// of contended requests; without it master 0 has fixed priority.
module memory_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  // Master 0: core port
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  // Master 1: loader/debug port
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  // Slave port
  output logic                  s_req,
  output logic                  s_we,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic                  s_ack
);

  localparam int unsigned CntW       = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned CntLastInt = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CntLastInt);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

  arb_state_e            state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic pick_grant;
  logic pick_valid;
  logic last_grant;
  logic rr_en;
  logic timeout_hit;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_grant_q;

  // Remember the most recent winner; reset value makes the first contended
  // grant go to the core.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= M_LOADER;
    end else if (state_q == StIdle && pick_valid) begin
      last_grant_q <= pick_grant;
    end
  end

  assign last_grant = last_grant_q;
  assign rr_en      = 1'b1;
`else
  assign last_grant = M_LOADER;
  assign rr_en      = 1'b0;
`endif

  arb_pick2 u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .rr_en      (rr_en),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  // The last permitted ISSUE cycle is the one where the counter still shows
  // TIMEOUT_CYCLES-1 before incrementing.
  assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

  // Next-state and datapath capture for the transfer FSM.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          we_d    = (pick_grant == M_LOADER) ? m1_we    : m0_we;
          addr_d  = (pick_grant == M_LOADER) ? m1_addr  : m0_addr;
          wdata_d = (pick_grant == M_LOADER) ? m1_wdata : m0_wdata;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        // A slave ack in the timeout cycle still completes normally.
        if (s_ack) begin
          rdata_d = s_rdata;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and captured-transfer registers; reset abandons any transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      grant_q <= M_CORE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from state and registers only.
  always_comb begin
    s_req    = (state_q == StIssue);
    s_we     = we_q;
    s_addr   = addr_q;
    s_wdata  = wdata_q;
    m0_ack   = (state_q == StResp) && (grant_q == M_CORE);
    m1_ack   = (state_q == StResp) && (grant_q == M_LOADER);
    m0_err   = m0_ack && err_q;
    m1_err   = m1_ack && err_q;
    m0_rdata = rdata_q;
    m1_rdata = rdata_q;
  end

  // Only one master is ever acknowledged, and an error always rides on an ack.
  a_ack_onehot : assert property (@(posedge clk) disable iff (!reset) !(m0_ack && m1_ack));
  a_err_m0 : assert property (@(posedge clk) disable iff (!reset) m0_err |-> m0_ack);
  a_err_m1 : assert property (@(posedge clk) disable iff (!reset) m1_err |-> m1_ack);

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration and handshake rules.
// A second instance with a short timeout covers the abort path.
module tb_memory_arbiter;

`ifdef ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] s_rdata;
  logic        s_ack;

  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err, s_req, s_we;

  logic [31:0] to_m0_rdata, to_m1_rdata, to_s_addr, to_s_wdata;
  logic        to_m0_ack, to_m0_err, to_m1_ack, to_m1_err, to_s_req, to_s_we;

  int checks;
  int errors;

  memory_arbiter u_dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  memory_arbiter #(.TIMEOUT_CYCLES(4)) u_dut_to (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(to_m0_rdata), .m0_ack(to_m0_ack), .m0_err(to_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(to_m1_rdata), .m1_ack(to_m1_ack), .m1_err(to_m1_err),
    .s_req(to_s_req), .s_we(to_s_we), .s_addr(to_s_addr), .s_wdata(to_s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    s_ack = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    // Deliver non-zero read data so the reset clear is observable.
    m0_req = 1'b1; m0_addr = 32'h44;
    tick();
    s_ack = 1'b1; s_rdata = 32'hCAFE_F00D;
    tick();
    s_ack = 1'b0; m0_req = 1'b0;
    tick();
    // Reset while both masters request.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'hFFFF_0000; m0_wdata = 32'h1234;
    m1_req = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (s_req !== 1'b0 || s_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_sreq: got req=%b we=%b want 0 0", s_req, s_we);
    end
    checks++;
    if (s_addr !== 32'h0 || s_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_saddr: got %h/%h want 0/0", s_addr, s_wdata);
    end
    checks++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_acks: got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err});
    end
    checks++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", m0_rdata, m1_rdata);
    end
    clear_inputs();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_read();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
    tick();
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h10 || s_we !== 1'b0) begin
      errors++;
      $display("FAIL basic_issue: got req=%b addr=%h we=%b want 1 10 0", s_req, s_addr, s_we);
    end
    s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF;
    tick();
    s_ack = 1'b0; s_rdata = 32'h0BAD_0BAD;
    checks++;
    if (m0_ack !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || m0_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_resp: got ack=%b data=%h err=%b want 1 deadbeef 0",
               m0_ack, m0_rdata, m0_err);
    end
    checks++;
    if (m1_ack !== 1'b0 || s_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_resp_other: got m1_ack=%b s_req=%b want 0 0", m1_ack, s_req);
    end
    m0_req = 1'b0;
    tick();
    checks++;
    if (m0_ack !== 1'b0 || s_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got ack=%b s_req=%b want 0 0", m0_ack, s_req);
    end
  endtask

  task automatic test_back_to_back();
    logic        last;
    logic        w;
    logic [31:0] d;
    do_reset();
    last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m0_req = 1'b1; m0_addr = 32'h1000 + i;
      m1_req = 1'b1; m1_addr = 32'h2000 + i;
      w = RR ? ~last : 1'b0;
      last = w;
      tick();
      checks++;
      if (s_req !== 1'b1 || s_addr !== (w ? 32'h2000 + i : 32'h1000 + i)) begin
        errors++;
        $display("FAIL b2b_grant[%0d]: got req=%b addr=%h want 1 %h", i, s_req, s_addr,
                 w ? 32'h2000 + i : 32'h1000 + i);
      end
      d = $urandom;
      s_ack = 1'b1; s_rdata = d;
      tick();
      s_ack = 1'b0;
      checks++;
      if ({m1_ack, m0_ack} !== (w ? 2'b10 : 2'b01) || (w ? m1_rdata : m0_rdata) !== d) begin
        errors++;
        $display("FAIL b2b_ack[%0d]: got acks=%b data=%h want %b %h", i, {m1_ack, m0_ack},
                 w ? m1_rdata : m0_rdata, w ? 2'b10 : 2'b01, d);
      end
      if (w) m1_req = 1'b0;
      else m0_req = 1'b0;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_hold_capture();
    do_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h100; m1_wdata = 32'h55;
    tick();
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (s_req !== 1'b1 || s_we !== 1'b1 || s_addr !== 32'h100 || s_wdata !== 32'h55 ||
          m1_ack !== 1'b0) begin
        errors++;
        $display("FAIL hold_issue[%0d]: got req=%b we=%b addr=%h wdata=%h ack=%b want 1 1 100 55 0",
                 c, s_req, s_we, s_addr, s_wdata, m1_ack);
      end
      m1_addr = $urandom; m1_wdata = $urandom; m1_we = 1'b0;
      s_ack = (c == 5);
      tick();
    end
    s_ack = 1'b0;
    checks++;
    if (m1_ack !== 1'b1 || m1_err !== 1'b0 || m0_ack !== 1'b0 || s_req !== 1'b0) begin
      errors++;
      $display("FAIL hold_resp: got m1_ack=%b m1_err=%b m0_ack=%b s_req=%b want 1 0 0 0",
               m1_ack, m1_err, m0_ack, s_req);
    end
    m1_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h18;
    tick();
    s_ack = 1'b1; s_rdata = 32'hA5A5_5A5A;
    tick();
    s_ack = 1'b0;
    checks++;
    if (to_m0_ack !== 1'b1 || to_m0_rdata !== 32'hA5A5_5A5A) begin
      errors++;
      $display("FAIL to_prime: got ack=%b data=%h want 1 a5a55a5a", to_m0_ack, to_m0_rdata);
    end
    m0_req = 1'b0;
    tick();
    m0_req = 1'b1; m0_addr = 32'h20;
    tick();
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (to_s_req !== 1'b1 || to_m0_ack !== 1'b0) begin
        errors++;
        $display("FAIL to_issue[%0d]: got req=%b ack=%b want 1 0", c, to_s_req, to_m0_ack);
      end
      tick();
    end
    checks++;
    if (to_m0_ack !== 1'b1 || to_m0_err !== 1'b1 || to_m0_rdata !== 32'h0 || to_s_req !== 1'b0) begin
      errors++;
      $display("FAIL to_abort: got ack=%b err=%b data=%h s_req=%b want 1 1 0 0",
               to_m0_ack, to_m0_err, to_m0_rdata, to_s_req);
    end
    checks++;
    if (to_m1_ack !== 1'b0 || to_m1_err !== 1'b0) begin
      errors++;
      $display("FAIL to_other: got ack=%b err=%b want 0 0", to_m1_ack, to_m1_err);
    end
    m0_req = 1'b0;
    tick();
    tick();
    checks++;
    if (to_s_req !== 1'b0 || to_m0_ack !== 1'b0 || to_m0_err !== 1'b0) begin
      errors++;
      $display("FAIL to_idle: got req=%b ack=%b err=%b want 0 0 0", to_s_req, to_m0_ack, to_m0_err);
    end
  endtask

  task automatic test_ack_at_limit();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h24;
    tick();
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (to_s_req !== 1'b1 || to_m0_ack !== 1'b0) begin
        errors++;
        $display("FAIL limit_issue[%0d]: got req=%b ack=%b want 1 0", c, to_s_req, to_m0_ack);
      end
      if (c == 4) begin
        s_ack = 1'b1; s_rdata = 32'h1234_5678;
      end
      tick();
    end
    s_ack = 1'b0;
    checks++;
    if (to_m0_ack !== 1'b1 || to_m0_err !== 1'b0 || to_m0_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL limit_resp: got ack=%b err=%b data=%h want 1 0 12345678",
               to_m0_ack, to_m0_err, to_m0_rdata);
    end
    m0_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h30;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h77;
    tick();
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h30) begin
      errors++;
      $display("FAIL mid_issue: got req=%b addr=%h want 1 30", s_req, s_addr);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (s_req !== 1'b0 || s_addr !== 32'h0 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got req=%b addr=%h ack=%b want 0 0 0", s_req, s_addr, m0_ack);
    end
    m0_req = 1'b0;
    tick();
    checks++;
    if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_noack: got %b%b want 00", m0_ack, m1_ack);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h40 || s_we !== 1'b1 || s_wdata !== 32'h77) begin
      errors++;
      $display("FAIL mid_regrant: got req=%b addr=%h we=%b wdata=%h want 1 40 1 77",
               s_req, s_addr, s_we, s_wdata);
    end
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    checks++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_resp: got m1_ack=%b m0_ack=%b want 1 0", m1_ack, m0_ack);
    end
    m1_req = 1'b0;
    tick();
  endtask

  // Randomized traffic against a transaction-level model: pending requests
  // per master, arbitration rule, captured fields and slave latency.
  task automatic test_random();
    bit          pend[2];
    logic        we_m[2];
    logic [31:0] addr_m[2];
    logic [31:0] wd_m[2];
    logic        last;
    logic        w;
    int          lat;
    int          k;
    logic [31:0] exp_d;
    do_reset();
    last = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < 2; j++) begin
        if (!pend[j] && $urandom_range(0, 1) == 1) begin
          pend[j] = 1'b1; we_m[j] = 1'($urandom); addr_m[j] = $urandom; wd_m[j] = $urandom;
        end
      end
      if (!pend[0] && !pend[1]) begin
        k = $urandom_range(0, 1);
        pend[k] = 1'b1; we_m[k] = 1'($urandom); addr_m[k] = $urandom; wd_m[k] = $urandom;
      end
      m0_req = pend[0]; m0_we = we_m[0]; m0_addr = addr_m[0]; m0_wdata = wd_m[0];
      m1_req = pend[1]; m1_we = we_m[1]; m1_addr = addr_m[1]; m1_wdata = wd_m[1];
      s_ack = 1'($urandom);
      s_rdata = $urandom;
      if (pend[0] && pend[1]) w = RR ? ~last : 1'b0;
      else w = pend[1];
      last = w;
      tick();
      lat = $urandom_range(1, 5);
      exp_d = $urandom;
      for (int c = 1; c <= lat; c++) begin
        checks++;
        if (s_req !== 1'b1 || s_we !== we_m[w] || s_addr !== addr_m[w] ||
            s_wdata !== wd_m[w] || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
          errors++;
          $display("FAIL rnd_issue[%0d.%0d]: got req=%b we=%b addr=%h wd=%h acks=%b%b want 1 %b %h %h 00",
                   n, c, s_req, s_we, s_addr, s_wdata, m1_ack, m0_ack, we_m[w], addr_m[w], wd_m[w]);
        end
        if (w) begin
          m1_addr = $urandom; m1_wdata = $urandom; m1_we = 1'($urandom);
        end else begin
          m0_addr = $urandom; m0_wdata = $urandom; m0_we = 1'($urandom);
        end
        s_ack = (c == lat);
        s_rdata = (c == lat) ? exp_d : $urandom;
        tick();
      end
      // Spurious slave ack during RESP must have no effect.
      s_ack = 1'($urandom);
      s_rdata = $urandom;
      checks++;
      if ({m1_ack, m0_ack} !== (w ? 2'b10 : 2'b01) || (w ? m1_rdata : m0_rdata) !== exp_d ||
          m0_err !== 1'b0 || m1_err !== 1'b0 || s_req !== 1'b0) begin
        errors++;
        $display("FAIL rnd_resp[%0d]: got acks=%b data=%h errs=%b%b s_req=%b want %b %h 00 0",
                 n, {m1_ack, m0_ack}, w ? m1_rdata : m0_rdata, m1_err, m0_err, s_req,
                 w ? 2'b10 : 2'b01, exp_d);
      end
      pend[w] = 1'b0;
      if (w) m1_req = 1'b0;
      else m0_req = 1'b0;
      tick();
      s_ack = 1'b0;
      checks++;
      if (s_req !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
        errors++;
        $display("FAIL rnd_idle[%0d]: got req=%b acks=%b%b want 0 00", n, s_req, m1_ack, m0_ack);
      end
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_basic_read();
    test_back_to_back();
    test_hold_capture();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_issue();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
